z80_ld_bcde_sequencer: RTL and testbench

Execution sequencer for the Z80 8-bit indirect accumulator load/store group: LD A,(BC) 0x0A, LD A,(DE) 0x1A, LD (BC),A 0x02 and LD (DE),A 0x12.
- Accepts a decoded single-byte opcode and selects BC or DE.
- Runs one memory bus cycle with wait-state handshake.
- For loads, writes A.
- Emits a one-cycle z80fi-style retirement record for the formal insn-spec checkers.
- Sits between the core's decode stage, register file and memory bus.

---
 rtl/z80_ld_bcde_sequencer.sv | 146 ++++++++++++++
 tb/tb_z80_ld_bcde_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/z80_ld_bcde_sequencer.sv
// Execution sequencer for LD A,(BC) / LD A,(DE) / LD (BC),A / LD (DE),A.
// One memory cycle with wait-state handshake, optional A writeback, then a retirement pulse.
module z80_ld_bcde_sequencer #(
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        opcode,
  input  logic [15:0]       pc_in,
  output logic              busy,
  output logic              illegal,
  output logic              reg_pair_sel,
  input  logic [15:0]       pair_data,
  input  logic [7:0]        a_data,
  output logic              a_we,
  output logic [7:0]        a_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [15:0]       mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              retire_valid,
  output logic [15:0]       retire_pc_next,
  output logic [15:0]       retire_mem_addr,
  output logic [7:0]        retire_data,
  output logic              retire_is_load,
  output logic [WAIT_W-1:0] retire_waits
);

  // state | meaning
  // IDLE  | waiting for start; pair select follows opcode[4] directly
  // MEM   | memory cycle in progress, held until mem_ack
  // WB    | load only: write captured byte into A
  // RET   | retirement record valid for one cycle
  typedef enum logic [1:0] {IDLE, MEM, WB, RET} state_t;

  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  state_t state, state_nxt;

  logic              legal;
  logic              accept;
  logic              sel_q;
  logic              load_q;
  logic [15:0]       pc_q;
  logic [15:0]       addr_q;
  logic [7:0]        stdata_q;
  logic [7:0]        rdata_q;
  logic [WAIT_W-1:0] waits_q;
  logic              illegal_q;

  assign legal  = (opcode[7:5] == 3'b000) && (opcode[2:0] == 3'b010);
  assign accept = (state == IDLE) && start && legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = MEM;
      MEM:  if (mem_ack) state_nxt = load_q ? WB : RET;
      WB:   state_nxt = RET;
      RET:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    illegal      = illegal_q;
    reg_pair_sel = (state == IDLE) ? opcode[4] : sel_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    a_we         = 1'b0;
    a_wdata      = '0;
    retire_valid = 1'b0;
    case (state)
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = ~load_q;
        mem_addr  = addr_q;
        mem_wdata = load_q ? 8'h00 : stdata_q;
      end
      WB: begin
        a_we    = 1'b1;
        a_wdata = rdata_q;
      end
      RET: retire_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q           <= 1'b0;
      load_q          <= 1'b0;
      pc_q            <= '0;
      addr_q          <= '0;
      stdata_q        <= '0;
      rdata_q         <= '0;
      waits_q         <= '0;
      illegal_q       <= 1'b0;
      retire_pc_next  <= '0;
      retire_mem_addr <= '0;
      retire_data     <= '0;
      retire_is_load  <= 1'b0;
      retire_waits    <= '0;
    end else begin
      illegal_q <= (state == IDLE) && start && !legal;
      if (accept) begin
        sel_q    <= opcode[4];
        load_q   <= opcode[3];
        pc_q     <= pc_in;
        addr_q   <= pair_data;
        stdata_q <= a_data;
        waits_q  <= '0;
      end
      if (state == MEM) begin
        if (mem_ack) begin
          rdata_q <= mem_rdata;
        end else if (waits_q != WAIT_MAX) begin
          waits_q <= waits_q + 1'b1;
        end
      end
      // Retire fields are loaded on entry to RET and then held until the next retirement.
      if (state_nxt == RET && state != RET) begin
        retire_pc_next  <= pc_q + 16'd1;
        retire_mem_addr <= addr_q;
        retire_is_load  <= load_q;
        retire_waits    <= waits_q;
        retire_data     <= load_q ? rdata_q : stdata_q;
      end
    end
  end

endmodule

// File: tb/tb_z80_ld_bcde_sequencer.sv
// Directed bench for z80_ld_bcde_sequencer; expected A writes and retire records go through scoreboards.
module tb_z80_ld_bcde_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  opcode;
  logic [15:0] pc_in;
  logic        busy, illegal, reg_pair_sel;
  logic [15:0] pair_data;
  logic [7:0]  a_data;
  logic        a_we;
  logic [7:0]  a_wdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        retire_valid;
  logic [15:0] retire_pc_next, retire_mem_addr;
  logic [7:0]  retire_data;
  logic        retire_is_load;
  logic [3:0]  retire_waits;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [15:0] pc_next;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        is_load;
    logic [3:0]  waits;
  } ret_t;

  ret_t       ret_q[$];
  logic [7:0] a_q[$];

  z80_ld_bcde_sequencer #(.WAIT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .pc_in(pc_in),
    .busy(busy), .illegal(illegal), .reg_pair_sel(reg_pair_sel),
    .pair_data(pair_data), .a_data(a_data), .a_we(a_we), .a_wdata(a_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .retire_valid(retire_valid), .retire_pc_next(retire_pc_next),
    .retire_mem_addr(retire_mem_addr), .retire_data(retire_data),
    .retire_is_load(retire_is_load), .retire_waits(retire_waits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: pop on every DUT-produced A write or retirement.
  always @(negedge clk) begin
    if (a_we) begin
      if (a_q.size() == 0) begin
        check("a_we_unexpected", 32'(a_we), 32'd0);
      end else begin
        logic [7:0] ea;
        ea = a_q.pop_front();
        check("a_wdata", 32'(a_wdata), 32'(ea));
      end
    end
    if (retire_valid) begin
      if (ret_q.size() == 0) begin
        check("retire_unexpected", 32'(retire_valid), 32'd0);
      end else begin
        ret_t er;
        er = ret_q.pop_front();
        check("retire_pc_next", 32'(retire_pc_next), 32'(er.pc_next));
        check("retire_mem_addr", 32'(retire_mem_addr), 32'(er.addr));
        check("retire_data", 32'(retire_data), 32'(er.data));
        check("retire_is_load", 32'(retire_is_load), 32'(er.is_load));
        check("retire_waits", 32'(retire_waits), 32'(er.waits));
      end
    end
  end

  // One legal instruction: drive start, serve the memory cycle after `waits` wait states.
  task automatic run_op(input logic [7:0] op, input logic [15:0] pair, input logic [7:0] a,
                        input logic [15:0] pc, input int waits, input logic [7:0] rdata,
                        input bit hold_start);
    ret_t        er;
    logic        is_load;
    logic        sel;
    logic [7:0]  data;
    is_load = op[3];
    sel     = op[4];
    data    = is_load ? rdata : a;
    er.pc_next = pc + 16'd1;
    er.addr    = pair;
    er.data    = data;
    er.is_load = is_load;
    er.waits   = (waits > 15) ? 4'd15 : 4'(waits);
    ret_q.push_back(er);
    if (is_load) a_q.push_back(rdata);

    start = 1'b1; opcode = op; pair_data = pair; a_data = a; pc_in = pc;
    #1;
    check("sel_idle", 32'(reg_pair_sel), 32'(sel));
    tick();
    if (hold_start) begin
      opcode = {3'b000, ~sel, 4'b1010};
      pair_data = 16'h5555; a_data = 8'hEE; pc_in = 16'h2222;
    end else begin
      start = 1'b0;
    end
    for (int i = 0; i <= waits; i++) begin
      check("mem_req", 32'(mem_req), 32'd1);
      check("mem_we", 32'(mem_we), 32'(!is_load));
      check("mem_addr", 32'(mem_addr), 32'(pair));
      check("mem_wdata", 32'(mem_wdata), is_load ? 32'd0 : 32'(a));
      check("sel_held", 32'(reg_pair_sel), 32'(sel));
      check("busy_mem", 32'(busy), 32'd1);
      mem_ack   = (i == waits);
      mem_rdata = (i == waits) ? rdata : 8'hA5;
      tick();
    end
    mem_ack = 1'b0;
    check("mem_req_drop", 32'(mem_req), 32'd0);
    if (is_load) begin
      check("a_we_wb", 32'(a_we), 32'd1);
      tick();
    end
    check("retire_valid", 32'(retire_valid), 32'd1);
    check("busy_ret", 32'(busy), 32'd1);
    check("a_we_ret", 32'(a_we), 32'd0);
    tick();
    start = 1'b0;
    check("busy_idle", 32'(busy), 32'd0);
    check("retire_done", 32'(retire_valid), 32'd0);
  endtask

  task automatic run_illegal(input logic [7:0] op);
    start = 1'b1; opcode = op; pc_in = 16'h0300; pair_data = 16'h4444;
    tick();
    start = 1'b0;
    check("illegal_pulse", 32'(illegal), 32'd1);
    check("illegal_busy", 32'(busy), 32'd0);
    check("illegal_mem_req", 32'(mem_req), 32'd0);
    tick();
    check("illegal_clear", 32'(illegal), 32'd0);
    check("illegal_mem_req2", 32'(mem_req), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; opcode = 8'h00; pc_in = '0; pair_data = '0;
    a_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_a_we", 32'(a_we), 32'd0);
    check("rst_retire_valid", 32'(retire_valid), 32'd0);
    check("rst_retire_pc", 32'(retire_pc_next), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    tick();

    run_op(8'h0A, 16'h1234, 8'h77, 16'h0100, 0, 8'h5A, 1'b0);   // LD A,(BC)
    run_op(8'h12, 16'hBEEF, 8'hC3, 16'h0200, 3, 8'h00, 1'b0);   // LD (DE),A, 3 waits
    run_illegal(8'h22);
    run_illegal(8'h1B);
    run_op(8'h1A, 16'h8001, 8'h11, 16'h0400, 20, 8'h3C, 1'b0);  // saturating waits
    run_op(8'h0A, 16'h0F0F, 8'h22, 16'hFFFF, 2, 8'h96, 1'b1);   // start held while busy, pc wrap
    run_op(8'h02, 16'h7E7E, 8'h81, 16'h1000, 1, 8'h00, 1'b0);   // accepted right after RET

    // Reset during MEM with ack pending: nothing may retire or write A afterwards.
    start = 1'b1; opcode = 8'h1A; pair_data = 16'h6060; a_data = 8'h00; pc_in = 16'h0500;
    tick();
    start = 1'b0;
    check("pre_reset_mem_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    tick();
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hDD;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("post_reset_busy", 32'(busy), 32'd0);

    check("ret_q_empty", 32'(ret_q.size()), 32'd0);
    check("a_q_empty", 32'(a_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
